hamming_secded_pipe: RTL

- Parametrised, pipelined Hamming SEC-DED decoder (single-error correct, double-error detect) with valid/ready handshake on both sides.
- Generalises the combinational 8-bit single-error decoder:
  - any data width;
  - an added overall-parity bit;
  - error classification;
  - saturating error-event counters.
- Sits between the code-word source (memory/link) and the data consumer.
- Throughput is one word per cycle when the consumer is not stalling.

---
 rtl/hamming_secded_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hamming_secded_pipe.sv
// rtl/hamming_secded_pipe.sv - two-stage pipelined Hamming SEC-DED decoder with error counters
module hamming_secded_pipe #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 8,
    localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int N      = DATA_W + PAR_W,
    localparam int CW     = N + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_err,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  unc_cnt,
    input  logic              cnt_clr
);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CORR = 2'b01;
    localparam logic [1:0] ERR_UNC  = 2'b10;
    localparam logic [1:0] ERR_OVRL = 2'b11;

    logic              s2_adv;
    logic              s1_adv;

    logic              s1_valid_q, s1_valid_d;
    logic [CW-1:0]     s1_code_q,  s1_code_d;
    logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;
    logic              s1_par_q,   s1_par_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [1:0]        out_err_q,   out_err_d;
    logic [PAR_W-1:0]  out_syn_q,   out_syn_d;
    logic [CNT_W-1:0]  corr_cnt_q,  corr_cnt_d;
    logic [CNT_W-1:0]  unc_cnt_q,   unc_cnt_d;

    logic [PAR_W-1:0]  syn_in;
    logic              syn_in_range;
    logic [1:0]        err_x;
    logic [CW-1:0]     fixed_code;
    logic [DATA_W-1:0] data_x;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        syn_in = '0;
        for (int p = 1; p <= N; p++) begin
            if (in_code[CW-p]) begin
                syn_in = syn_in ^ PAR_W'(p);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code;
                s1_syn_d  = syn_in;
                s1_par_d  = ^in_code;
            end
        end
    end

    // A non-zero syndrome beyond N cannot name a real bit, so it is treated as uncorrectable.
    assign syn_in_range = (int'(s1_syn_q) <= N);

    always_comb begin
        if (s1_syn_q == '0) begin
            err_x = s1_par_q ? ERR_OVRL : ERR_NONE;
        end else if (s1_par_q && syn_in_range) begin
            err_x = ERR_CORR;
        end else begin
            err_x = ERR_UNC;
        end
    end

    // Data positions are shifted in ascending order, so position 3 ends up in the MSB.
    always_comb begin
        fixed_code = s1_code_q;
        data_x     = '0;
        for (int p = 1; p <= N; p++) begin
            if (err_x == ERR_CORR && int'(s1_syn_q) == p) begin
                fixed_code[CW-p] = ~s1_code_q[CW-p];
            end
        end
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                data_x = {data_x[DATA_W-2:0], fixed_code[CW-p]};
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_syn_d   = out_syn_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = data_x;
                out_err_d  = err_x;
                out_syn_d  = s1_syn_q;
            end
        end
    end

    always_comb begin
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_err_q == ERR_CORR || out_err_q == ERR_OVRL) begin
                if (corr_cnt_q != '1) begin
                    corr_cnt_d = corr_cnt_q + CNT_W'(1);
                end
            end else if (out_err_q == ERR_UNC) begin
                if (unc_cnt_q != '1) begin
                    unc_cnt_d = unc_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            out_syn_q   <= '0;
            corr_cnt_q  <= '0;
            unc_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_syn_q   <= out_syn_d;
            corr_cnt_q  <= corr_cnt_d;
            unc_cnt_q   <= unc_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_err      = out_err_q;
    assign out_syndrome = out_syn_q;
    assign corr_cnt     = corr_cnt_q;
    assign unc_cnt      = unc_cnt_q;

endmodule
